rib_ram_slave: RTL and testbench

RIB_RAM_SLAVE -- requirements
Module: rib_ram_slave

---
 rtl/rib_ram_slave.sv | 162 ++++++++++++++++
 tb/tb_rib_ram_slave.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rib_ram_slave.sv
// Purpose : single-port word RAM slave on the RIB core bus, with a fixed wait-state count.
// Latency : WAIT+1 cycles from the cycle req_i is sampled to the ack_o cycle.
// Backpress: hold_o stalls the core from request until the response; req_i is ignored while busy.
//
// Ports
//   clk, rst            : clock and asynchronous active-high reset
//   req_i, we_i         : access request and direction (1 = write)
//   addr_i, data_i      : byte address and write data, captured on the request edge
//   data_o, ack_o       : read data and response strobe, valid only in the response cycle
//   hold_o              : core pipeline hold, high from request cycle through the last wait cycle
//   err_o               : address fell outside [BASE, BASE+4*DEPTH)
module rib_ram_slave #(
    parameter int          DEPTH = 1024,
    parameter int          WAIT  = 2,
    parameter logic [31:0] BASE  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        hold_o,
    output logic        err_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        rd_ok_q, rd_ok_d;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word_q;

    // Address/direction of the access currently being steered toward RESP.
    // In IDLE that is the live bus (WAIT=0 goes straight to RESP), otherwise
    // the captured copy.
    logic [31:0]   acc_addr;
    logic          acc_we;
    logic          enter_resp;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          mem_we;

    // Byte-lane bits never select anything: accesses are always full words.
    logic unused_byte_bits;
    assign unused_byte_bits = ^{addr_q[1:0], addr_i[1:0]};

    // BASE is aligned to the window size, so range membership reduces to
    // matching the bits above the word index.
    function automatic logic in_range(input logic [31:0] a);
        return a[31:AW+2] == BASE[31:AW+2];
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        acc_addr   = addr_q;
        acc_we     = we_q;

        case (state_q)
            ST_IDLE: begin
                acc_addr = addr_i;
                acc_we   = we_i;
                if (req_i) begin
                    addr_d  = addr_i;
                    we_d    = we_i;
                    wdata_d = data_i;
                    if (WAIT == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_CNT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // <= rather than == so a corrupted count can never wedge the FSM
                if (cnt_q <= 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ack_d   = enter_resp;
        err_d   = enter_resp && !in_range(acc_addr);
        rd_ok_d = enter_resp && !acc_we && in_range(acc_addr);

        rd_idx  = acc_addr[AW+1:2];
        wr_idx  = addr_q[AW+1:2];
        // The write lands on the edge that ends RESP, so a read issued right
        // after can only sample the array after the new value is in.
        mem_we  = (state_q == ST_RESP) && we_q && in_range(addr_q);

        // Gated by rst so a request held during reset does not stall the core.
        hold_o  = !rst && (((state_q == ST_IDLE) && req_i) || (state_q == ST_WAIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rd_ok_q <= rd_ok_d;
        end
    end

    // Storage is deliberately not reset; the read port is a plain registered
    // read so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_idx] <= wdata_q;
        end
        rd_word_q <= mem[rd_idx];
    end

    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign data_o = rd_ok_q ? rd_word_q : '0;

endmodule

// File: tb/tb_rib_ram_slave.sv
module tb_rib_ram_slave;

    localparam int          DEPTH = 16;
    localparam int          WAIT  = 2;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    // WAIT=2 instance
    logic        req, we;
    logic [31:0] addr, wdata, rdata;
    logic        ack, hold, err;
    // WAIT=0 instance
    logic        req0, we0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ack0, hold0, err0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    rib_ram_slave #(.DEPTH(DEPTH), .WAIT(WAIT), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .data_i(wdata),
        .data_o(rdata), .ack_o(ack), .hold_o(hold), .err_o(err)
    );

    rib_ram_slave #(.DEPTH(DEPTH), .WAIT(0), .BASE(BASE)) dut0 (
        .clk(clk), .rst(rst), .req_i(req0), .we_i(we0), .addr_i(addr0), .data_i(wdata0),
        .data_o(rdata0), .ack_o(ack0), .hold_o(hold0), .err_o(err0)
    );

    function automatic bit model_in_range(input logic [31:0] a);
        longint unsigned la, lo, hi;
        la = a;
        lo = BASE;
        hi = lo + 4 * DEPTH;
        return (la >= lo) && (la < hi);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Drives one access on the WAIT=2 instance starting just after a rising
    // edge and records what was observed; returns just after a rising edge.
    task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              output int hold_n, output int ack_c, output logic [31:0] rd,
                              output logic e, output logic stray);
        hold_n = 0; ack_c = -1; rd = '0; e = 1'b0; stray = 1'b0;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int c = 0; c < 20 && ack_c < 0; c++) begin
            @(negedge clk);
            if (hold === 1'b1) hold_n++;
            if (ack === 1'b1) begin
                ack_c = c; rd = rdata; e = err;
            end else if (rdata !== 32'h0 || err !== 1'b0) begin
                stray = 1'b1;
            end
            @(posedge clk); #1;
            if (c == 0) begin
                req = 1'b0; we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
            end
        end
        @(negedge clk);
        if (ack !== 1'b0 || rdata !== 32'h0 || err !== 1'b0 || hold !== 1'b0) stray = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 1'b1; we = 1'b0; addr = BASE; wdata = 32'h0;
        req0 = 1'b1; we0 = 1'b0; addr0 = BASE; wdata0 = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++; if (hold !== 1'b0) begin n_bad++; $display("FAIL reset_hold: got %b expected 0", hold); end
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", ack); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", rdata); end
        n_cmp++; if (hold0 !== 1'b0) begin n_bad++; $display("FAIL reset_hold0: got %b expected 0", hold0); end
        n_cmp++; if (ack0 !== 1'b0) begin n_bad++; $display("FAIL reset_ack0: got %b expected 0", ack0); end
        req = 1'b0; req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fill;
        int h, ac; logic [31:0] rd; logic e, s; logic [31:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            run_access(1'b1, BASE + 32'(4 * i), d, h, ac, rd, e, s);
            model[i] = d;
            n_cmp++; if (ac !== WAIT + 1) begin n_bad++; $display("FAIL fill_ack_cycle[%0d]: got %0d expected %0d", i, ac, WAIT + 1); end
            n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL fill_err[%0d]: got %b expected 0", i, e); end
        end
    endtask

    task automatic test_write_read;
        int h, ac; logic [31:0] rd; logic e, s;
        run_access(1'b1, BASE + 32'd8, 32'hDEAD_BEEF, h, ac, rd, e, s);
        model[2] = 32'hDEAD_BEEF;
        n_cmp++; if (h !== 3) begin n_bad++; $display("FAIL wr_hold_cycles: got %0d expected 3", h); end
        n_cmp++; if (ac !== 3) begin n_bad++; $display("FAIL wr_ack_cycle: got %0d expected 3", ac); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b expected 0", e); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL wr_data: got %h expected 0", rd); end
        n_cmp++; if (s !== 1'b0) begin n_bad++; $display("FAIL wr_stray: got %b expected 0", s); end
        run_access(1'b0, BASE + 32'd8, $urandom, h, ac, rd, e, s);
        n_cmp++; if (ac !== 3) begin n_bad++; $display("FAIL rd_ack_cycle: got %0d expected 3", ac); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        n_cmp++; if (s !== 1'b0) begin n_bad++; $display("FAIL rd_stray: got %b expected 0", s); end
    endtask

    task automatic test_out_of_range;
        int h, ac; logic [31:0] rd; logic e, s;
        logic [31:0] oor [4];
        logic        oor_we [4];
        oor[0] = BASE + 32'(4 * DEPTH); oor_we[0] = 1'b0;
        oor[1] = BASE - 32'd4;          oor_we[1] = 1'b0;
        oor[2] = BASE + 32'(4 * DEPTH); oor_we[2] = 1'b1;
        oor[3] = 32'h0000_0000;         oor_we[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_access(oor_we[i], oor[i], $urandom, h, ac, rd, e, s);
            n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL oor_err[%0d]: got %b expected 1", i, e); end
            n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_data[%0d]: got %h expected 0", i, rd); end
            n_cmp++; if (ac !== WAIT + 1) begin n_bad++; $display("FAIL oor_ack_cycle[%0d]: got %0d expected %0d", i, ac, WAIT + 1); end
        end
        run_access(1'b0, BASE, $urandom, h, ac, rd, e, s);
        n_cmp++; if (rd !== model[0]) begin n_bad++; $display("FAIL oor_no_corrupt: got %h expected %h", rd, model[0]); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL oor_base_err: got %b expected 0", e); end
    endtask

    task automatic test_unaligned;
        int h, ac; logic [31:0] rd; logic e, s;
        run_access(1'b1, BASE + 32'd13, 32'hA5A5_A5A5, h, ac, rd, e, s);
        model[3] = 32'hA5A5_A5A5;
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL unal_err: got %b expected 0", e); end
        run_access(1'b0, BASE + 32'd12, $urandom, h, ac, rd, e, s);
        n_cmp++; if (rd !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL unal_read: got %h expected a5a5a5a5", rd); end
    endtask

    task automatic test_random;
        int h, ac; logic [31:0] rd; logic e, s;
        logic [31:0] a, d, exp_rd; logic w, exp_e; int off;
        for (int i = 0; i < 40; i++) begin
            off = int'($urandom_range(0, 4 * DEPTH + 31)) - 16;
            a = BASE + 32'(off);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            exp_e  = !model_in_range(a);
            exp_rd = (!exp_e && !w) ? model[model_idx(a)] : 32'h0;
            run_access(w, a, d, h, ac, rd, e, s);
            if (!exp_e && w) model[model_idx(a)] = d;
            n_cmp++; if (e !== exp_e) begin n_bad++; $display("FAIL rand_err[%0d] a=%h: got %b expected %b", i, a, e, exp_e); end
            n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL rand_data[%0d] a=%h: got %h expected %h", i, a, rd, exp_rd); end
            n_cmp++; if (ac !== WAIT + 1 || h !== WAIT + 1) begin n_bad++; $display("FAIL rand_timing[%0d]: ack %0d hold %0d expected %0d", i, ac, h, WAIT + 1); end
            n_cmp++; if (s !== 1'b0) begin n_bad++; $display("FAIL rand_stray[%0d]: got %b expected 0", i, s); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v [2];
        v[0] = $urandom; v[1] = $urandom;
        for (int k = 0; k < 2; k++) begin
            req0 = 1'b1; we0 = 1'b1; addr0 = BASE + 32'(4 * k); wdata0 = v[k];
            @(posedge clk); #1;
            req0 = 1'b0;
            @(negedge clk);
            n_cmp++; if (ack0 !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_ack[%0d]: got %b expected 1", k, ack0); end
            @(posedge clk); #1;
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = BASE;
        @(negedge clk);   // cycle 0
        n_cmp++; if (hold0 !== 1'b1 || ack0 !== 1'b0) begin n_bad++; $display("FAIL b2b_c0: hold %b ack %b expected 1 0", hold0, ack0); end
        @(posedge clk); #1;
        addr0 = BASE + 32'd4;
        @(negedge clk);   // cycle 1
        n_cmp++; if (ack0 !== 1'b1 || hold0 !== 1'b0) begin n_bad++; $display("FAIL b2b_c1: ack %b hold %b expected 1 0", ack0, hold0); end
        n_cmp++; if (rdata0 !== v[0]) begin n_bad++; $display("FAIL b2b_c1_data: got %h expected %h", rdata0, v[0]); end
        @(posedge clk); #1;
        @(negedge clk);   // cycle 2
        n_cmp++; if (hold0 !== 1'b1 || ack0 !== 1'b0 || rdata0 !== 32'h0) begin n_bad++; $display("FAIL b2b_c2: hold %b ack %b data %h expected 1 0 0", hold0, ack0, rdata0); end
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);   // cycle 3
        n_cmp++; if (ack0 !== 1'b1) begin n_bad++; $display("FAIL b2b_c3_ack: got %b expected 1", ack0); end
        n_cmp++; if (rdata0 !== v[1]) begin n_bad++; $display("FAIL b2b_c3_data: got %h expected %h", rdata0, v[1]); end
        @(posedge clk); #1;
        @(negedge clk);   // cycle 4
        n_cmp++; if (ack0 !== 1'b0 || hold0 !== 1'b0) begin n_bad++; $display("FAIL b2b_c4: ack %b hold %b expected 0 0", ack0, hold0); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int h, ac; logic [31:0] rd; logic e, s; logic seen_ack;
        req = 1'b1; we = 1'b1; addr = BASE + 32'd12; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (hold !== 1'b0 || ack !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin n_bad++; $display("FAIL rstmid_outputs: hold %b ack %b err %b data %h expected all 0", hold, ack, err, rdata); end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        seen_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ack !== 1'b0) seen_ack = 1'b1;
        end
        n_cmp++; if (seen_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_ack: got %b expected 0", seen_ack); end
        @(posedge clk); #1;
        run_access(1'b0, BASE + 32'd12, $urandom, h, ac, rd, e, s);
        n_cmp++; if (rd !== model[3]) begin n_bad++; $display("FAIL rstmid_prior_value: got %h expected %h", rd, model[3]); end
        n_cmp++; if (ac !== WAIT + 1) begin n_bad++; $display("FAIL rstmid_recover_ack: got %0d expected %0d", ac, WAIT + 1); end
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        test_reset;
        test_fill;
        test_write_read;
        test_out_of_range;
        test_unaligned;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
